// File: rtl/mc_state_seq.sv
// Multi-cycle MIPS state sequencer: walks each instruction through its states,
// owns the imem/dmem ready handshakes, a wait watchdog and a retired-instruction counter.
module mc_state_seq #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             stall,
  input  logic             imem_rdy,
  input  logic             dmem_rdy,
  output logic [3:0]       state,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [3:0] {
    S_IF     = 4'b0000,
    S_ID     = 4'b0001,
    S_MA     = 4'b0010,
    S_MR     = 4'b0011,
    S_MEMWB  = 4'b0100,
    S_MW     = 4'b0101,
    S_EXE    = 4'b0110,
    S_WB     = 4'b0111,
    S_BRANCH = 4'b1000,
    S_JUMP   = 4'b1001,
    S_IFW    = 4'b1010
  } state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               illegal_q, illegal_d;
  logic               bus_err_q, bus_err_d;
  logic               timeout;
  logic               retire;
  state_t             decode_st;
  logic               decode_ok;

  // ID decode; funct is only meaningful for the SPECIAL (000000) opcode
  always_comb begin
    decode_st = S_IFW;
    decode_ok = 1'b1;
    case (opcode)
      6'b100011, 6'b100000, 6'b101011, 6'b101000: decode_st = S_MA;
      6'b001000, 6'b001001, 6'b001101, 6'b001111: decode_st = S_EXE;
      6'b000100:                                  decode_st = S_BRANCH;
      6'b000010, 6'b000011:                       decode_st = S_JUMP;
      6'b000000: begin
        case (funct)
          6'b100001, 6'b100011, 6'b101010: decode_st = S_EXE;
          6'b001000, 6'b001001:            decode_st = S_JUMP;
          default:                         decode_ok = 1'b0;
        endcase
      end
      default: decode_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    cnt_d     = cnt_q;
    illegal_d = 1'b0;
    bus_err_d = 1'b0;
    retire    = 1'b0;
    timeout   = (wait_q == WAIT_W'(TIMEOUT - 1));
    if (!stall) begin
      case (state_q)
        S_IFW: begin
          if (imem_rdy) begin
            state_d = S_IF;
          end else if (timeout) begin
            bus_err_d = 1'b1;
          end
        end
        S_IF:  state_d = S_ID;
        S_ID: begin
          state_d   = decode_st;
          illegal_d = ~decode_ok;
        end
        // opcode bit 3 separates stores (sw/sb) from loads (lw/lb)
        S_MA:  state_d = opcode[3] ? S_MW : S_MR;
        S_MR: begin
          if (dmem_rdy) begin
            state_d = S_MEMWB;
          end else if (timeout) begin
            state_d   = S_IFW;
            bus_err_d = 1'b1;
          end
        end
        S_MW: begin
          if (dmem_rdy) begin
            state_d = S_IFW;
            retire  = 1'b1;
          end else if (timeout) begin
            state_d   = S_IFW;
            bus_err_d = 1'b1;
          end
        end
        S_MEMWB, S_WB, S_BRANCH, S_JUMP: begin
          state_d = S_IFW;
          retire  = 1'b1;
        end
        S_EXE:   state_d = S_WB;
        default: state_d = S_IFW;
      endcase

      // a timeout in IFW re-enters IFW, so it restarts the count too
      if ((state_d != state_q) || bus_err_d) begin
        wait_d = '0;
      end else if ((state_q == S_IFW) || (state_q == S_MR) || (state_q == S_MW)) begin
        wait_d = wait_q + WAIT_W'(1);
      end else begin
        wait_d = '0;
      end

      if (retire) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IFW;
      wait_q    <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign state     = state_q;
  assign imem_req  = rst_n && (state_q == S_IFW);
  assign dmem_req  = rst_n && ((state_q == S_MR) || (state_q == S_MW));
  assign dmem_we   = (state_q == S_MW);
  assign illegal   = illegal_q;
  assign bus_err   = bus_err_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_mc_state_seq.sv
// Directed bench for mc_state_seq: hand-derived state walks per instruction class,
// handshake waits, timeout, stall freeze and mid-instruction reset.
module tb_mc_state_seq;

  localparam logic [3:0] ST_IF = 4'b0000, ST_ID = 4'b0001, ST_MA = 4'b0010, ST_MR = 4'b0011;
  localparam logic [3:0] ST_MEMWB = 4'b0100, ST_MW = 4'b0101, ST_EXE = 4'b0110, ST_WB = 4'b0111;
  localparam logic [3:0] ST_BR = 4'b1000, ST_JMP = 4'b1001, ST_IFW = 4'b1010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode, funct;
  logic        stall, imem_rdy, dmem_rdy;
  logic [3:0]  state;
  logic        imem_req, dmem_req, dmem_we, illegal, bus_err;
  logic [31:0] instr_cnt;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_cnt = 32'd0;

  mc_state_seq #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .stall(stall),
    .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy), .state(state), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .illegal(illegal), .bus_err(bus_err),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // from IFW: present the instruction and let fetch complete; returns in ID
  task automatic start_instr(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct = fn;
    imem_rdy = 1'b1;
    step();
    imem_rdy = 1'b0;
    step();
  endtask

  task automatic test_reset();
    #12;
    checks++; if (state !== ST_IFW) begin failures++; $display("FAIL reset_state: got %b expected %b", state, ST_IFW); end
    checks++; if (imem_req !== 1'b0 || dmem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b%b expected 00", imem_req, dmem_req); end
    checks++; if (illegal !== 1'b0 || bus_err !== 1'b0) begin failures++; $display("FAIL reset_pulses: got %b%b expected 00", illegal, bus_err); end
    checks++; if (instr_cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt: got %0d expected 0", instr_cnt); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL release_imem_req: got %b expected 1", imem_req); end
    $display("tx reset done");
  endtask

  task automatic test_addu();
    logic [3:0] exp_seq [6];
    exp_seq = '{ST_IFW, ST_IF, ST_ID, ST_EXE, ST_WB, ST_IFW};
    opcode = 6'b000000;
    funct = 6'b100001;
    imem_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++; if (state !== exp_seq[i]) begin failures++; $display("FAIL addu_state[%0d]: got %b expected %b", i, state, exp_seq[i]); end
      if (i < 5) begin
        step();
        imem_rdy = 1'b0;
      end
    end
    exp_cnt++;
    checks++; if (instr_cnt !== exp_cnt) begin failures++; $display("FAIL addu_cnt: got %0d expected %0d", instr_cnt, exp_cnt); end
    $display("tx addu cnt=%0d", instr_cnt);
  endtask

  task automatic test_load_wait();
    start_instr(6'b100011, 6'b000000);
    step();
    checks++; if (state !== ST_MA) begin failures++; $display("FAIL lw_ma: got %b expected %b", state, ST_MA); end
    dmem_rdy = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      checks++; if (state !== ST_MR || dmem_req !== 1'b1 || dmem_we !== 1'b0) begin
        failures++; $display("FAIL lw_mr[%0d]: got st=%b req=%b we=%b expected st=%b req=1 we=0", i, state, dmem_req, dmem_we, ST_MR);
      end
      if (i == 2) dmem_rdy = 1'b1;
      step();
    end
    dmem_rdy = 1'b0;
    checks++; if (state !== ST_MEMWB) begin failures++; $display("FAIL lw_memwb: got %b expected %b", state, ST_MEMWB); end
    step();
    exp_cnt++;
    checks++; if (state !== ST_IFW || instr_cnt !== exp_cnt) begin failures++; $display("FAIL lw_retire: got st=%b cnt=%0d expected st=%b cnt=%0d", state, instr_cnt, ST_IFW, exp_cnt); end
    $display("tx lw cnt=%0d", instr_cnt);
  endtask

  task automatic test_store();
    start_instr(6'b101000, 6'b000000);
    step();
    checks++; if (state !== ST_MA || dmem_we !== 1'b0) begin failures++; $display("FAIL sb_ma: got st=%b we=%b expected st=%b we=0", state, dmem_we, ST_MA); end
    dmem_rdy = 1'b1;
    step();
    checks++; if (state !== ST_MW || dmem_we !== 1'b1 || dmem_req !== 1'b1) begin failures++; $display("FAIL sb_mw: got st=%b we=%b req=%b expected st=%b we=1 req=1", state, dmem_we, dmem_req, ST_MW); end
    step();
    dmem_rdy = 1'b0;
    exp_cnt++;
    checks++; if (state !== ST_IFW || dmem_we !== 1'b0 || instr_cnt !== exp_cnt) begin failures++; $display("FAIL sb_retire: got st=%b we=%b cnt=%0d expected st=%b we=0 cnt=%0d", state, dmem_we, instr_cnt, ST_IFW, exp_cnt); end
    $display("tx sb cnt=%0d", instr_cnt);
  endtask

  task automatic test_decode();
    start_instr(6'b001000, 6'b001000);
    step();
    checks++; if (state !== ST_EXE) begin failures++; $display("FAIL addi_funct_jr: got %b expected %b", state, ST_EXE); end
    step(); step();
    exp_cnt++;
    checks++; if (state !== ST_IFW || instr_cnt !== exp_cnt) begin failures++; $display("FAIL addi_retire: got st=%b cnt=%0d expected st=%b cnt=%0d", state, instr_cnt, ST_IFW, exp_cnt); end
    $display("tx addi cnt=%0d", instr_cnt);

    start_instr(6'b000000, 6'b001000);
    step();
    checks++; if (state !== ST_JMP) begin failures++; $display("FAIL jr_jump: got %b expected %b", state, ST_JMP); end
    step();
    exp_cnt++;
    checks++; if (state !== ST_IFW || instr_cnt !== exp_cnt) begin failures++; $display("FAIL jr_retire: got st=%b cnt=%0d expected st=%b cnt=%0d", state, instr_cnt, ST_IFW, exp_cnt); end
    $display("tx jr cnt=%0d", instr_cnt);

    start_instr(6'b000100, 6'b000000);
    step();
    checks++; if (state !== ST_BR) begin failures++; $display("FAIL beq_branch: got %b expected %b", state, ST_BR); end
    step();
    exp_cnt++;
    checks++; if (instr_cnt !== exp_cnt) begin failures++; $display("FAIL beq_cnt: got %0d expected %0d", instr_cnt, exp_cnt); end
    $display("tx beq cnt=%0d", instr_cnt);

    start_instr(6'b111111, 6'b000000);
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL illegal_early: got %b expected 0", illegal); end
    step();
    checks++; if (state !== ST_IFW || illegal !== 1'b1 || instr_cnt !== exp_cnt) begin failures++; $display("FAIL illegal_pulse: got st=%b ill=%b cnt=%0d expected st=%b ill=1 cnt=%0d", state, illegal, instr_cnt, ST_IFW, exp_cnt); end
    step();
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL illegal_width: got %b expected 0", illegal); end
    $display("tx illegal cnt=%0d", instr_cnt);
  endtask

  task automatic test_timeout();
    start_instr(6'b100011, 6'b000000);
    step(); step();
    dmem_rdy = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      checks++; if (state !== ST_MR || bus_err !== 1'b0) begin failures++; $display("FAIL to_mr[%0d]: got st=%b err=%b expected st=%b err=0", i, state, bus_err, ST_MR); end
      step();
    end
    checks++; if (state !== ST_IFW || bus_err !== 1'b1 || instr_cnt !== exp_cnt) begin failures++; $display("FAIL to_exit: got st=%b err=%b cnt=%0d expected st=%b err=1 cnt=%0d", state, bus_err, instr_cnt, ST_IFW, exp_cnt); end
    step();
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL to_pulse_width: got %b expected 0", bus_err); end
    $display("tx lw timeout cnt=%0d", instr_cnt);

    start_instr(6'b100011, 6'b000000);
    step(); step();
    for (int i = 1; i <= 15; i++) step();
    checks++; if (state !== ST_MR) begin failures++; $display("FAIL rdy16_mr: got %b expected %b", state, ST_MR); end
    dmem_rdy = 1'b1;
    step();
    dmem_rdy = 1'b0;
    checks++; if (state !== ST_MEMWB || bus_err !== 1'b0) begin failures++; $display("FAIL rdy16_win: got st=%b err=%b expected st=%b err=0", state, bus_err, ST_MEMWB); end
    step();
    exp_cnt++;
    checks++; if (instr_cnt !== exp_cnt) begin failures++; $display("FAIL rdy16_cnt: got %0d expected %0d", instr_cnt, exp_cnt); end
    $display("tx lw rdy-at-limit cnt=%0d", instr_cnt);
  endtask

  task automatic test_stall();
    start_instr(6'b100011, 6'b000000);
    step(); step();
    dmem_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) step();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (state !== ST_MR || bus_err !== 1'b0) begin failures++; $display("FAIL stall_hold[%0d]: got st=%b err=%b expected st=%b err=0", i, state, bus_err, ST_MR); end
    end
    stall = 1'b0;
    // MR cycles 5..16 still remain before the watchdog fires
    for (int i = 5; i <= 16; i++) begin
      checks++; if (state !== ST_MR) begin failures++; $display("FAIL stall_resume[%0d]: got %b expected %b", i, state, ST_MR); end
      step();
    end
    checks++; if (state !== ST_IFW || bus_err !== 1'b1 || instr_cnt !== exp_cnt) begin failures++; $display("FAIL stall_timeout: got st=%b err=%b cnt=%0d expected st=%b err=1 cnt=%0d", state, bus_err, instr_cnt, ST_IFW, exp_cnt); end
    $display("tx lw stalled timeout cnt=%0d", instr_cnt);
  endtask

  task automatic test_reset_mid();
    start_instr(6'b001101, 6'b000000);
    step();
    checks++; if (state !== ST_EXE) begin failures++; $display("FAIL ori_exe: got %b expected %b", state, ST_EXE); end
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = 32'd0;
    checks++; if (state !== ST_IFW || instr_cnt !== exp_cnt || imem_req !== 1'b0) begin failures++; $display("FAIL async_reset: got st=%b cnt=%0d ireq=%b expected st=%b cnt=0 ireq=0", state, instr_cnt, imem_req, ST_IFW); end
    step();
    rst_n = 1'b1;
    step();
    checks++; if (state !== ST_IFW || instr_cnt !== exp_cnt) begin failures++; $display("FAIL post_reset: got st=%b cnt=%0d expected st=%b cnt=0", state, instr_cnt, ST_IFW); end
    $display("tx ori reset-abandoned cnt=%0d", instr_cnt);
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = 6'd0;
    funct = 6'd0;
    stall = 1'b0;
    imem_rdy = 1'b0;
    dmem_rdy = 1'b0;
    test_reset();
    test_addu();
    test_load_wait();
    test_store();
    test_decode();
    test_timeout();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mc_state_seq.md
Name: mc_state_seq

Overview:
- Sequencer for the multi-cycle MIPS core. It generates the 4-bit `state` code that the control-output decoder consumes.
- Walks each instruction through fetch, decode, execute, memory and writeback states, chosen from opcode/funct.
- Owns the memory request/ready handshakes, a wait-timeout watchdog, and a retired-instruction counter.
- Sits between the instruction register and the control decoder.

Parameters:
- TIMEOUT, 16: maximum cycles spent waiting for a ready signal before aborting.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  IR[31:26]; must be stable from ID onward.
- funct  in  6  IR[5:0].
- stall  in  1  freezes the state, wait counter and instruction counter while high.
- imem_rdy  in  1  instruction memory data valid.
- dmem_rdy  in  1  data memory read data valid / write accepted.
- state  out  4  current state code.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data request is a write.
- illegal  out  1  one-cycle pulse on an undecodable instruction.
- bus_err  out  1  one-cycle pulse on a handshake timeout.
- instr_cnt  out  CNT_W  retired instructions.

Behaviour:
- State codes (fixed):
  - IF=0000, ID=0001, MA=0010, MR=0011, MemWB=0100, MW=0101
  - Exe=0110, WB=0111, Branch=1000, Jump=1001, IFW=1010
  - Codes 1011-1111 are unused; if one is ever reached, the next state is IFW.
- Reset (async assert, sync release):
  - state=IFW, wait counter=0, instr_cnt=0.
  - illegal=0, bus_err=0.
  - imem_req=0 and dmem_req=0 while rst_n is low.
- Combinational outputs:
  - imem_req = (state==IFW).
  - dmem_req = (state==MR || state==MW).
  - dmem_we = (state==MW).
- IF lasts exactly one cycle, because the decoder asserts PCWr/IRWr for every cycle spent in IF.
- Transitions (evaluated only when stall=0; with stall=1 everything holds, including the wait counter):
  - IFW: imem_rdy=1 -> IF; otherwise stay.
  - IF -> ID.
  - ID, decoding by opcode:
    - lw(100011), lb(100000), sw(101011), sb(101000) -> MA.
    - addi(001000), addiu(001001), ori(001101), lui(001111) -> Exe.
    - beq(000100) -> Branch.
    - j(000010), jal(000011) -> Jump.
    - opcode 000000, decoded by funct: addu(100001), subu(100011), slt(101010) -> Exe; jr(001000), jalr(001001) -> Jump.
    - funct is examined only when opcode==000000. funct 001000 under a non-zero opcode does not mean jr.
    - Anything else -> IFW with illegal=1 for one cycle.
  - MA: loads -> MR; stores -> MW.
  - MR: dmem_rdy=1 -> MemWB; otherwise stay.
  - MW: dmem_rdy=1 -> IFW; otherwise stay.
  - MemWB, WB, Branch, Jump -> IFW.
  - Exe -> WB.
- Wait counter:
  - Counts cycles spent in IFW, MR or MW.
  - Clears on entering any state.
  - If it reaches TIMEOUT-1 with ready still low, the next state is IFW and bus_err=1 for one cycle.
  - If ready and timeout coincide, ready wins: normal transition, no bus_err.
- instr_cnt:
  - Increments by 1 on the cycle of a retiring transition: MemWB->IFW, WB->IFW, MW->IFW (ready), Branch->IFW, Jump->IFW.
  - Illegal and timeout exits do not count.
  - Wraps modulo 2^CNT_W.
- Reset mid-instruction: the sequence is abandoned immediately and no count is recorded.
- Latencies with zero wait:
  - R-type/immediate: 5 cycles IFW..WB.
  - Load: 6.
  - Store: 5.
  - beq/j/jal/jr/jalr: 4.

Test Plan:
- Reset, then addu (opcode 0, funct 100001) with imem_rdy=1 -> states 1010,0000,0001,0110,0111,1010; instr_cnt=1.
- lw with dmem_rdy delayed 3 cycles -> MR held 3 cycles, dmem_req=1 and dmem_we=0 throughout, then MemWB; instr_cnt +1.
- sb with dmem_rdy=1 -> MA,MW,IFW; dmem_we=1 for the single MW cycle; retire counted.
- opcode 001000 with funct 001000 -> Exe, not Jump. opcode 0 with funct 001000 -> Jump. opcode 111111 -> illegal pulse, back to IFW, count unchanged.
- TIMEOUT=16, dmem_rdy held low in MR -> exit to IFW after 16 MR cycles, bus_err pulse, no count. Repeat with rdy rising on the 16th cycle -> MemWB, no bus_err.
- stall=1 for 5 cycles in MR with dmem_rdy=0 -> state and wait counter frozen. Separately, rst_n low while in Exe -> state=1010 and instr_cnt=0 immediately, without waiting for a clock edge.
